// File: rtl/riscv_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mon_pkg
// Purpose  : Shared types and defaults for the riscv-tests end-of-test monitor
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mon_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } mon_state_e;

  localparam int unsigned DEF_DONE_REG    = 26;
  localparam int unsigned DEF_RESULT_REG  = 27;
  localparam int unsigned DEF_TESTNUM_REG = 3;
  localparam int unsigned DEF_CON_REG     = 15;

  localparam int unsigned PASS_VALUE = 1;

  function automatic logic is_terminal(input mon_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mon_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mon_sync_fifo
// Purpose  : Show-ahead synchronous FIFO; a push into a full FIFO is accepted
//            only when a pop frees a slot in the same cycle
// Revision : 1.0 - initial release
// ============================================================================
module mon_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Head is forced to zero while empty so stale storage never leaks out
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/riscv_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : riscv_test_monitor
// Purpose  : Snoops register write-back to detect riscv-tests completion,
//            with settle delay, watchdog, counters and a console buffer
// Revision : 1.0 - initial release
// ============================================================================
module riscv_test_monitor
  import riscv_mon_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned DONE_REG       = DEF_DONE_REG,
  parameter int unsigned RESULT_REG     = DEF_RESULT_REG,
  parameter int unsigned TESTNUM_REG    = DEF_TESTNUM_REG,
  parameter int unsigned CON_REG        = DEF_CON_REG,
  parameter int unsigned SETTLE_CYCLES  = 20,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned CON_DEPTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en_i,
  input  logic [4:0]       wb_addr_i,
  input  logic [XLEN-1:0]  wb_data_i,
  input  logic             retire_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [XLEN-1:0]  fail_testnum_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             con_valid_o,
  output logic [7:0]       con_char_o,
  input  logic             con_ready_i,
  output logic             con_overflow_o
);

  localparam logic [4:0]       DONE_IDX    = 5'(DONE_REG);
  localparam logic [4:0]       RESULT_IDX  = 5'(RESULT_REG);
  localparam logic [4:0]       TESTNUM_IDX = 5'(TESTNUM_REG);
  localparam logic [4:0]       CON_IDX     = 5'(CON_REG);
  localparam logic [XLEN-1:0]  PASS_DATA   = XLEN'(PASS_VALUE);
  localparam logic [15:0]      SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam bit               TO_EN       = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LIMIT    = CNT_W'(TIMEOUT_CYCLES - 1);

  mon_state_e       state_q, state_d;
  logic [15:0]      settle_q, settle_d;
  logic [XLEN-1:0]  result_sh_q, result_sh_d;
  logic [XLEN-1:0]  testnum_sh_q, testnum_sh_d;
  logic [XLEN-1:0]  fail_testnum_q, fail_testnum_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic             overflow_q, overflow_d;

  logic             wb_hit, hit_done, hit_result, hit_testnum, hit_con;
  logic [XLEN-1:0]  result_now, testnum_now;
  logic             run_phase, timeout_hit;
  logic             con_pop, fifo_full, fifo_empty;

  // x0 is hard-wired zero, so writes to it are never meaningful
  assign wb_hit      = wb_en_i && (wb_addr_i != 5'd0);
  assign hit_done    = wb_hit && (wb_addr_i == DONE_IDX) && (wb_data_i == PASS_DATA);
  assign hit_result  = wb_hit && (wb_addr_i == RESULT_IDX);
  assign hit_testnum = wb_hit && (wb_addr_i == TESTNUM_IDX);
  assign hit_con     = wb_hit && (wb_addr_i == CON_IDX);

  // Bypass lets a write in the final settle cycle participate in the verdict
  assign result_now  = hit_result  ? wb_data_i : result_sh_q;
  assign testnum_now = hit_testnum ? wb_data_i : testnum_sh_q;

  assign run_phase   = (state_q == ST_RUN) || (state_q == ST_SETTLE);
  assign timeout_hit = TO_EN && run_phase && (cycle_cnt_q == TO_LIMIT);

  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    result_sh_d    = hit_result  ? wb_data_i : result_sh_q;
    testnum_sh_d   = hit_testnum ? wb_data_i : testnum_sh_q;
    fail_testnum_d = fail_testnum_q;
    cycle_cnt_d    = cycle_cnt_q;
    retire_cnt_d   = retire_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (timeout_hit) begin
          state_d = ST_TIMEOUT;
        end else if (hit_done) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (timeout_hit) begin
          state_d = ST_TIMEOUT;
        end else if (settle_q == 16'd0) begin
          if (result_now == PASS_DATA) begin
            state_d = ST_PASS;
          end else begin
            state_d        = ST_FAIL;
            fail_testnum_d = testnum_now;
          end
        end else begin
          settle_d = settle_q - 16'd1;
        end
      end
      default: state_d = state_q;
    endcase

    // Counters stop on the cycle the watchdog fires so they report the limit
    if (run_phase && !timeout_hit) begin
      if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
      if (retire_i && (retire_cnt_q != '1)) retire_cnt_d = retire_cnt_q + 1'b1;
    end

    done_d     = is_terminal(state_d);
    pass_d     = (state_d == ST_PASS);
    fail_d     = (state_d == ST_FAIL);
    timeout_d  = (state_d == ST_TIMEOUT);
    overflow_d = overflow_q || (hit_con && fifo_full && !con_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      settle_q       <= '0;
      result_sh_q    <= '0;
      testnum_sh_q   <= '0;
      fail_testnum_q <= '0;
      cycle_cnt_q    <= '0;
      retire_cnt_q   <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      result_sh_q    <= result_sh_d;
      testnum_sh_q   <= testnum_sh_d;
      fail_testnum_q <= fail_testnum_d;
      cycle_cnt_q    <= cycle_cnt_d;
      retire_cnt_q   <= retire_cnt_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      timeout_q      <= timeout_d;
      overflow_q     <= overflow_d;
    end
  end

  assign con_valid_o = !fifo_empty;
  assign con_pop     = con_valid_o && con_ready_i;

  mon_sync_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (hit_con),
    .data_i  (wb_data_i[7:0]),
    .pop_i   (con_pop),
    .data_o  (con_char_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign timeout_o      = timeout_q;
  assign fail_testnum_o = fail_testnum_q;
  assign cycle_cnt_o    = cycle_cnt_q;
  assign retire_cnt_o   = retire_cnt_q;
  assign con_overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_test_monitor
// Purpose  : Scoreboard bench for riscv_test_monitor (status and console)
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_test_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        retire;
  logic        done_o, pass_o, fail_o, timeout_o;
  logic [31:0] fail_testnum_o, cycle_cnt_o, retire_cnt_o;
  logic        con_valid_o, con_ready, con_overflow_o;
  logic [7:0]  con_char_o;

  riscv_test_monitor #(
    .SETTLE_CYCLES  (20),
    .TIMEOUT_CYCLES (1000),
    .CON_DEPTH      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_en_i        (wb_en),
    .wb_addr_i      (wb_addr),
    .wb_data_i      (wb_data),
    .retire_i       (retire),
    .done_o         (done_o),
    .pass_o         (pass_o),
    .fail_o         (fail_o),
    .timeout_o      (timeout_o),
    .fail_testnum_o (fail_testnum_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .retire_cnt_o   (retire_cnt_o),
    .con_valid_o    (con_valid_o),
    .con_char_o     (con_char_o),
    .con_ready_i    (con_ready),
    .con_overflow_o (con_overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pass;
    bit          fail;
    bit          tmo;
    logic [31:0] testnum;
    int          cyc;
    logic [31:0] cnt;
  } exp_status_t;

  exp_status_t exp_st_q[$];
  logic [7:0]  exp_ch_q[$];
  exp_status_t e;
  logic [7:0]  ec;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        done_prev = 1'b0;

  // Cycle index: 0 is the cycle right after the reset edge
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Status monitor: compares the verdict when done_o rises
  always @(negedge clk) begin
    if (done_o && !done_prev) begin
      if (exp_st_q.size() == 0) begin
        check("unexpected_done", done_o, 0);
      end else begin
        e = exp_st_q.pop_front();
        check("st_pass",    pass_o,         e.pass);
        check("st_fail",    fail_o,         e.fail);
        check("st_timeout", timeout_o,      e.tmo);
        check("st_testnum", fail_testnum_o, e.testnum);
        check("st_cycle",   cyc,            e.cyc);
        check("st_cnt",     cycle_cnt_o,    e.cnt);
      end
    end
    done_prev = done_o;
  end

  // Console monitor: compares each character as it is consumed
  always @(negedge clk) begin
    if (!rst && con_valid_o && con_ready) begin
      if (exp_ch_q.size() == 0) begin
        check("con_unexpected_valid", con_valid_o, 0);
      end else begin
        ec = exp_ch_q.pop_front();
        check("con_char", con_char_o, ec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wb_en = 1'b0;
    tick();
    rst   = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    while (!done_o && i < bound) begin
      tick();
      i++;
    end
    if (!done_o) check("wait_done_bound", done_o, 1);
    repeat (2) tick();
  endtask

  task automatic wait_drain(input int bound);
    int i = 0;
    while (con_valid_o && i < bound) begin
      tick();
      i++;
    end
    check("drain_bound", con_valid_o, 0);
  endtask

  task automatic push_st(input bit p, input bit f, input bit t, input logic [31:0] tn,
                         input int c, input logic [31:0] n);
    exp_status_t s;
    s.pass = p; s.fail = f; s.tmo = t; s.testnum = tn; s.cyc = c; s.cnt = n;
    exp_st_q.push_back(s);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_done"},     done_o,         0);
    check({tag, "_pass"},     pass_o,         0);
    check({tag, "_fail"},     fail_o,         0);
    check({tag, "_timeout"},  timeout_o,      0);
    check({tag, "_testnum"},  fail_testnum_o, 0);
    check({tag, "_cyclecnt"}, cycle_cnt_o,    0);
    check({tag, "_retire"},   retire_cnt_o,   0);
    check({tag, "_convalid"}, con_valid_o,    0);
    check({tag, "_conchar"},  con_char_o,     0);
    check({tag, "_overflow"}, con_overflow_o, 0);
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    retire = 1'b0; con_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Pass: x27=1 early, x26=1 at cycle 50, verdict at cycle 71
    do_reset();
    check_idle("reset");
    retire = 1'b1;
    push_st(1, 0, 0, 32'd0, 71, 32'd71);
    wait_cyc(10);
    wb_write(5'd27, 32'd1);
    wait_cyc(50);
    wb_write(5'd26, 32'd1);
    wait_cyc(70);
    check("pass_not_early", done_o, 0);
    wait_done(20);
    retire = 1'b0;
    repeat (3) tick();
    check("pass_cnt_frozen",    cycle_cnt_o,  71);
    check("pass_retire_frozen", retire_cnt_o, 71);
    check("pass_done_held",     done_o,       1);

    // Fail: testnum captured, later x3 writes ignored, console works after end
    do_reset();
    con_ready = 1'b1;
    push_st(0, 1, 0, 32'd5, 23, 32'd23);
    wb_write(5'd3, 32'd5);
    wb_write(5'd27, 32'd0);
    wb_write(5'd26, 32'd1);
    wait_done(40);
    exp_ch_q.push_back(8'h46);
    wb_write(5'd3, 32'd9);
    wb_write(5'd15, 32'h46);
    repeat (3) tick();
    check("fail_testnum_held", fail_testnum_o, 5);
    check("fail_flag_held",    fail_o,         1);
    check("fail_pass_low",     pass_o,         0);

    // x26=2 ignored, x0 ignored, last-settle-cycle x27=1 bypass gives pass
    do_reset();
    con_ready = 1'b0;
    wb_write(5'd27, 32'd0);
    wb_write(5'd26, 32'd2);
    wb_write(5'd0, 32'd1);
    wait_cyc(30);
    check("run_not_done",   done_o,      0);
    check("run_no_console", con_valid_o, 0);
    check("run_cycle_cnt",  cycle_cnt_o, 30);
    push_st(1, 0, 0, 32'd0, 51, 32'd51);
    wb_write(5'd26, 32'd1);
    wait_cyc(50);
    wb_write(5'd27, 32'd1);
    wait_done(20);

    // Watchdog
    do_reset();
    push_st(0, 0, 1, 32'd0, 1000, 32'd999);
    wait_done(1100);
    check("tmo_cnt_frozen", cycle_cnt_o, 999);

    // Console overflow, in-order drain, push into empty FIFO
    do_reset();
    con_ready = 1'b0;
    exp_ch_q.push_back(8'h48);
    exp_ch_q.push_back(8'h65);
    exp_ch_q.push_back(8'h6c);
    exp_ch_q.push_back(8'h6c);
    wb_write(5'd15, 32'h48);
    wb_write(5'd15, 32'h65);
    wb_write(5'd15, 32'h6c);
    wb_write(5'd15, 32'h6c);
    wb_write(5'd15, 32'h6f);
    check("ovf_set",       con_overflow_o, 1);
    check("ovf_valid",     con_valid_o,    1);
    check("ovf_head_char", con_char_o,     8'h48);
    con_ready = 1'b1;
    wait_drain(20);
    check("ovf_drained", exp_ch_q.size(), 0);
    exp_ch_q.push_back(8'h5a);
    wb_write(5'd15, 32'h5a);
    check("empty_push_visible", con_valid_o, 1);
    repeat (2) tick();
    check("ovf_sticky", con_overflow_o, 1);

    // Push into a full FIFO while popping is accepted
    do_reset();
    check("ovf_cleared", con_overflow_o, 0);
    con_ready = 1'b0;
    exp_ch_q.push_back(8'h61);
    exp_ch_q.push_back(8'h62);
    exp_ch_q.push_back(8'h63);
    exp_ch_q.push_back(8'h64);
    exp_ch_q.push_back(8'h65);
    wb_write(5'd15, 32'h61);
    wb_write(5'd15, 32'h62);
    wb_write(5'd15, 32'h63);
    wb_write(5'd15, 32'h64);
    con_ready = 1'b1;
    wb_write(5'd15, 32'h65);
    check("full_poppush_no_ovf", con_overflow_o, 0);
    wait_drain(20);
    check("full_poppush_drained", exp_ch_q.size(), 0);

    // Reset during SETTLE
    do_reset();
    con_ready = 1'b0;
    wb_write(5'd26, 32'd1);
    wb_write(5'd15, 32'h71);
    wait_cyc(8);
    check("settle_not_done", done_o, 0);
    do_reset();
    check_idle("midreset");
    repeat (30) tick();
    check("midreset_stays_run", done_o, 0);

    check("status_queue_empty", exp_st_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
